kmap_mux_scanner: RTL

//   Drives the {c,d} inputs of a K-map mux-input generator (4-bit mux_in, one bit per {a,b} select).

---
 rtl/kmap_pkg.sv | 20 ++
 rtl/kmap_mux_scanner.sv | 96 +++++++++
 2 files changed

// File: rtl/kmap_pkg.sv
// Shared types and helpers for the K-map mux-input scanner.
package kmap_pkg;

    localparam int unsigned TABLE_W = 16;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCapture,
        StDone
    } state_e;

    // Truth-table bit position for select {a,b} and driven {c,d}; a is the MSB.
    function automatic logic [3:0] tt_index(input logic [SEL_W-1:0] ab,
                                            input logic [SEL_W-1:0] cd);
        return {ab, cd};
    endfunction

endpackage

// File: rtl/kmap_mux_scanner.sv
// Steps {c,d} through 00..11, captures the generator's 4-bit mux_in at each step into a
// 16-entry truth table, and compares it against an expected table sampled at start.
module kmap_mux_scanner
    import kmap_pkg::*;
#(
    parameter int unsigned SETTLE = 0
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               start,
    output logic               c,
    output logic               d,
    input  logic [3:0]         mux_in,
    input  logic [TABLE_W-1:0] expected,
    output logic               busy,
    output logic               done,
    output logic               table_valid,
    output logic [TABLE_W-1:0] table_out,
    output logic               mismatch
);

    // Last settle count value before moving to capture; unused when SETTLE is 0.
    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

    state_e             state_q;
    logic [SEL_W-1:0]   cd_q;
    logic [3:0]         settle_cnt_q;
    logic [TABLE_W-1:0] expected_q;

    // Generator inputs come straight from the registered step so they never glitch.
    assign c = cd_q[1];
    assign d = cd_q[0];

    // Scan sequencer: state, step counter, settle counter and all registered outputs.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= StIdle;
            cd_q         <= '0;
            settle_cnt_q <= '0;
            expected_q   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_valid  <= 1'b0;
            table_out    <= '0;
            mismatch     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cd_q         <= '0;
                        settle_cnt_q <= '0;
                        table_out    <= '0;
                        table_valid  <= 1'b0;
                        mismatch     <= 1'b0;
                        expected_q   <= expected;
                        busy         <= 1'b1;
                        if (SETTLE > 0) state_q <= StSettle;
                        else            state_q <= StCapture;
                    end
                end
                StSettle: begin
                    if (settle_cnt_q == SettleLast) begin
                        settle_cnt_q <= '0;
                        state_q      <= StCapture;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 4'd1;
                    end
                end
                StCapture: begin
                    for (int i = 0; i < 4; i++) begin
                        table_out[tt_index(SEL_W'(i), cd_q)] <= mux_in[i];
                    end
                    if (cd_q == 2'd3) begin
                        state_q <= StDone;
                    end else begin
                        cd_q <= cd_q + 2'd1;
                        if (SETTLE > 0) state_q <= StSettle;
                        else            state_q <= StCapture;
                    end
                end
                StDone: begin
                    done        <= 1'b1;
                    table_valid <= 1'b1;
                    busy        <= 1'b0;
                    mismatch    <= (table_out != expected_q);
                    // Return the generator inputs to 00 while idle.
                    cd_q        <= '0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
